// File: rtl/dlx_pkg.sv
// Shared DLX definitions: fetch FSM states,
// fetch error codes and decoder opcodes.
package dlx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;

endpackage

// File: rtl/dlx_fetch_unit_if.sv
// Fetch handshakes: imem req/ack on one side,
// instruction valid/ack toward the decoder.
interface dlx_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr,
    output instr_valid,
    input  instr_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr,
    input  instr_valid,
    output instr_ack
  );

endinterface

// File: rtl/dlx_next_pc.sv
// Next-PC selection for branches and jumps,
// with a misaligned-target flag.
module dlx_next_pc (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        rs_zero,
  input  logic [31:0] rs_value,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] off26;
  logic [31:0] off16;
  logic        taken;

  assign off26 = {{6{instr[25]}}, instr};
  assign off16 = {{16{instr[15]}}, instr[15:0]};
  assign taken = (branch_eq & rs_zero)
               | (branch_ne & ~rs_zero);

  always_comb begin
    next_pc = pc_plus4;
    if (jump && jump_reg)
      next_pc = rs_value;
    else if (jump)
      next_pc = pc_plus4 + off26;
    else if (taken)
      next_pc = pc_plus4 + off16;
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX fetch stage: PC, imem fetch with timeout,
// instruction issue and redirect on retirement.
module dlx_fetch_unit
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  dlx_fetch_unit_if.master  bus,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  input  logic              branch_eq,
  input  logic              branch_ne,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              rs_zero,
  input  logic [31:0]       rs_value,
  output logic              halted,
  output logic [1:0]        err_code,
  output logic [31:0]       retired
);

  localparam logic [7:0] WAIT_LAST =
    8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] instr_q;
  logic [31:0] next_pc;
  logic        misaligned;

  assign pc_plus4        = pc + 32'd4;
  assign bus.imem_req    = (state == S_FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state == S_ISSUE);
  assign halted          = (state == S_HALT);

  dlx_next_pc u_next_pc (
    .pc_plus4   (pc_plus4),
    .instr      (instr_q[25:0]),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .jump       (jump),
    .jump_reg   (jump_reg),
    .rs_zero    (rs_zero),
    .rs_value   (rs_value),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      instr_q  <= 32'd0;
      retired  <= 32'd0;
      err_code <= ERR_NONE;
      wait_cnt <= 8'd0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_ack) begin
            instr_q  <= bus.imem_rdata;
            wait_cnt <= 8'd0;
            state    <= S_ISSUE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            // this cycle's miss makes the count MAX_WAIT
            if (wait_cnt == WAIT_LAST) begin
              err_code <= ERR_TIMEOUT;
              state    <= S_HALT;
            end
          end
        end
        S_ISSUE: begin
          if (bus.instr_ack) begin
            retired <= retired + 32'd1;
            if (misaligned) begin
              err_code <= ERR_MISALIGN;
              state    <= S_HALT;
            end else begin
              pc    <= next_pc;
              state <= S_FETCH;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dlx_fetch_unit.md
Name: dlx_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Holds the PC and fetches words from a variable-latency instruction memory using a req/ack handshake.
- Presents each fetched instruction word with a valid/ack handshake.
- On retirement, takes the decoder's branch/jump controls, computes the next PC and redirects fetch; faults halt the unit until reset.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MAX_WAIT, 16, maximum cycles in FETCH without imem_ack before timeout (legal range 1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched word
- instr  out  32  held instruction word, to decoder
- instr_valid  out  1  instr is valid (ISSUE state)
- instr_ack  in  1  consumer retires instr this cycle
- pc  out  32  address of current instr
- pc_plus4  out  32  pc + 4 (link value)
- branch_eq  in  1  beqz decoded
- branch_ne  in  1  bnez decoded
- jump  in  1  j/jal/jr/jalr decoded
- jump_reg  in  1  jr/jalr (qualifies jump)
- rs_zero  in  1  source register == 0
- rs_value  in  32  source register value (jr/jalr target)
- halted  out  1  unit in HALT
- err_code  out  2  00 none, 01 fetch timeout, 10 misaligned target
- retired  out  32  retired-instruction count, wraps modulo 2^32

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Values while rst is high: state=IDLE, pc=RESET_PC, instr=0, retired=0, err_code=00, wait counter=0, and imem_req, instr_valid, halted all 0.
- FSM states are IDLE, FETCH, ISSUE, HALT.
- IDLE: unconditionally moves to FETCH on the next edge, so imem_req rises one cycle after reset deassertion.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ack may arrive in the same cycle req first rises.
  - On imem_ack: instr<=imem_rdata, wait counter<=0, go to ISSUE.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT with no ack: err_code<=01, go to HALT.
  - An ack in the cycle the counter equals MAX_WAIT-1 is accepted normally.
- ISSUE: instr_valid=1, instr is stable. On instr_ack:
  - retired<=retired+1.
  - Next PC is computed with the priority below.
  - If next_pc[1:0]!=0: err_code<=10, go to HALT. pc is not updated and retired is still incremented.
  - Otherwise pc<=next_pc and go to FETCH.
- Next-PC priority (first match wins):
  - jump & jump_reg -> rs_value.
  - jump -> pc_plus4 + sext(instr[25:0]).
  - branch_eq & rs_zero -> pc_plus4 + sext(instr[15:0]).
  - branch_ne & ~rs_zero -> pc_plus4 + sext(instr[15:0]).
  - else -> pc_plus4.
  - Offsets are byte offsets with no shift; all arithmetic is 32-bit modulo (wrap, no overflow flag).
- HALT: all handshake outputs are 0 and halted=1. The only exit is rst.
- Ignored inputs:
  - imem_ack outside FETCH is ignored.
  - instr_ack outside ISSUE is ignored.
  - Decode inputs are sampled only on the instr_ack cycle.
- Reset mid-fetch or mid-issue aborts immediately. A stale imem_ack arriving after reset release, while in IDLE, is ignored.
- Output timing:
  - pc_plus4 is combinational from pc.
  - All other outputs are registered or decoded from the state register; there are no combinational in-to-out paths except pc_plus4.
- Minimum throughput: 2 cycles per instruction (ack same cycle as req, instr_ack on the first ISSUE cycle).

Decomposition:
- Shared package `dlx_pkg`:
  - FSM state encoding.
  - err_code constants ERR_NONE, ERR_TIMEOUT, ERR_MISALIGN.
  - Opcode constants, shared with the decoder.
- One sub-module: `dlx_next_pc`, combinational. Inputs are pc_plus4, instr, the controls, rs_zero and rs_value. It outputs next_pc and misaligned.

Test Plan:
- Reset/first fetch: reset with RESET_PC=0x100, release -> imem_req=1 with imem_addr=0x100 on the first cycle after release; return ack+0x2000_0000 -> instr_valid next cycle, instr=0x2000_0000, retired=0.
- Sequential fetch: 3 instrs, zero-latency ack, immediate instr_ack -> addresses 0x100, 0x104, 0x108; retired=3; 2 cycles per instruction.
- Branch: pc=0x200, branch_eq=1, rs_zero=1, imm16=0xFFF8 -> next fetch 0x1FC. Same with rs_zero=0 -> 0x204. branch_ne with rs_zero=0, imm16=0x0010 -> 0x214.
- Jumps:
  - jump=1, jump_reg=0, instr[25:0]=0x0000040, pc=0x200 -> 0x244.
  - jump=1, jump_reg=1, rs_value=0x3000 -> 0x3000.
  - jump_reg with rs_value=0x3002 -> halted=1, err_code=10, no further imem_req.
- Timeout: MAX_WAIT=4, withhold ack -> halted and err_code=01 after 4 FETCH cycles. With ack on the 4th FETCH cycle (counter=3) -> normal ISSUE, no error.
- Reset mid-operation: assert rst asynchronously during FETCH and again during ISSUE -> outputs immediately at reset values. Stale imem_ack in the IDLE cycle after release is ignored, and fetch restarts at RESET_PC.
